// File: rtl/data_sram_responder.sv
// In-order SRAM-style data responder: accepts requests on addr_ok, answers each
// with data_ok/rdata after a fixed latency from a local word-addressed RAM.
module data_sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int ADDR_LAT = 0,
    parameter int DATA_LAT = 1,
    parameter int QDEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_sram_req,
    input  logic                     data_sram_wr,
    input  logic [1:0]               data_sram_size,
    input  logic [3:0]               data_sram_wstrb,
    input  logic [31:0]              data_sram_addr,
    input  logic [31:0]              data_sram_wdata,
    output logic                     data_sram_addr_ok,
    output logic                     data_sram_data_ok,
    output logic [31:0]              data_sram_rdata,
    output logic [$clog2(QDEPTH):0]  outstanding
);

    localparam int PW = $clog2(QDEPTH);
    localparam int OW = PW + 1;
    localparam int WW = $clog2(ADDR_LAT + 1) + 1;

    // Handshake: a request transfers in any cycle where req and addr_ok are both
    // high. The response side has no back-pressure: data_ok is valid for exactly
    // one cycle per request, in acceptance order, and the master must take it.

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       q_rdata [QDEPTH];
    logic [3:0]        q_timer [QDEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [WW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              pop;
    logic [1:0]        size_unused;

    assign idx         = data_sram_addr[ADDR_W+1:2];
    assign size_unused = data_sram_size;

    assign data_sram_addr_ok = ~reset & data_sram_req
                             & (wait_cnt >= WW'(ADDR_LAT))
                             & (outstanding < OW'(QDEPTH));
    assign accept = data_sram_addr_ok;

    assign data_sram_data_ok = ~reset & (outstanding != '0) & (q_timer[head] == 4'd0);
    assign pop               = data_sram_data_ok;
    assign data_sram_rdata   = data_sram_data_ok ? q_rdata[head] : 32'd0;

    // Saturates at ADDR_LAT: only the comparison against ADDR_LAT matters.
    always_ff @(posedge clk) begin
        if (reset || accept || !data_sram_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WW'(ADDR_LAT)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // RAM deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < QDEPTH; j++) begin
            if (q_timer[j] != 4'd0) begin
                q_timer[j] <= q_timer[j] - 4'd1;
            end
        end
        if (accept) begin
            q_timer[tail] <= 4'(DATA_LAT - 1);
            q_rdata[tail] <= data_sram_wr ? 32'd0 : mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            outstanding <= '0;
        end else begin
            if (accept) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances with different latency settings,
// directed requests, and per-instance expected-response queues checked on data_ok.
module tb_data_sram_responder;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req     [3];
    logic        wr      [3];
    logic [1:0]  size    [3];
    logic [3:0]  strb    [3];
    logic [31:0] addr    [3];
    logic [31:0] wdata   [3];
    logic        addr_ok [3];
    logic        data_ok [3];
    logic [31:0] rdata   [3];
    logic [2:0]  outst   [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    int   lat  [3] = '{1, 5, 1};
    int   last [3] = '{-100, -100, -100};
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] pre_v [6] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222,
                               32'hA333_3333, 32'hA444_4444, 32'hA555_5555};

    data_sram_responder #(.ADDR_W(10), .ADDR_LAT(0), .DATA_LAT(1), .QDEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
        .data_sram_size(size[0]), .data_sram_wstrb(strb[0]), .data_sram_addr(addr[0]),
        .data_sram_wdata(wdata[0]), .data_sram_addr_ok(addr_ok[0]),
        .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0]), .outstanding(outst[0])
    );

    data_sram_responder #(.ADDR_W(10), .ADDR_LAT(0), .DATA_LAT(5), .QDEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
        .data_sram_size(size[1]), .data_sram_wstrb(strb[1]), .data_sram_addr(addr[1]),
        .data_sram_wdata(wdata[1]), .data_sram_addr_ok(addr_ok[1]),
        .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1]), .outstanding(outst[1])
    );

    data_sram_responder #(.ADDR_W(10), .ADDR_LAT(2), .DATA_LAT(1), .QDEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .data_sram_req(req[2]), .data_sram_wr(wr[2]),
        .data_sram_size(size[2]), .data_sram_wstrb(strb[2]), .data_sram_addr(addr[2]),
        .data_sram_wdata(wdata[2]), .data_sram_addr_ok(addr_ok[2]),
        .data_sram_data_ok(data_ok[2]), .data_sram_rdata(rdata[2]), .outstanding(outst[2])
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drivers: inputs change at posedge+1, outputs are sampled at negedge.
    task automatic issue(input int i, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input int exp_wait);
        int   waited;
        bit   got;
        exp_t e;
        req[i] = 1'b1; wr[i] = w; strb[i] = s; addr[i] = a; wdata[i] = d;
        waited = 0;
        got    = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (addr_ok[i]) begin
                got = 1;
            end else begin
                waited++;
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            if (exp_wait >= 0) chk("accept_wait", waited, exp_wait);
            e.data = w ? 32'd0 : exp_rd;
            e.cyc  = (cyc + lat[i] > last[i] + 1) ? cyc + lat[i] : last[i] + 1;
            last[i] = e.cyc;
            if (i == 0) q0.push_back(e);
            else if (i == 1) q1.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int i);
        int n;
        n = 1;
        for (int k = 0; k < 100 && n != 0; k++) begin
            @(negedge clk);
            n = (i == 0) ? q0.size() : q1.size();
        end
        if (n != 0) chk("drain_timeout", n, 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (data_ok[0]) begin
            if (q0.size() == 0) begin
                chk("unexpected_data_ok0", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("rdata0", rdata[0], e0.data);
                chk("resp_cycle0", cyc, e0.cyc);
            end
        end else begin
            chk("rdata_idle0", rdata[0], 32'd0);
            if (q0.size() != 0 && q0[0].cyc <= cyc) begin
                e0 = q0.pop_front();
                chk("missing_data_ok0", cyc, e0.cyc - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (data_ok[1]) begin
            if (q1.size() == 0) begin
                chk("unexpected_data_ok1", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("rdata1", rdata[1], e1.data);
                chk("resp_cycle1", cyc, e1.cyc);
            end
        end else begin
            chk("rdata_idle1", rdata[1], 32'd0);
            if (q1.size() != 0 && q1[0].cyc <= cyc) begin
                e1 = q1.pop_front();
                chk("missing_data_ok1", cyc, e1.cyc - 1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 0; wr[i] = 0; size[i] = 2'd2; strb[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        req[0] = 1'b1; wr[0] = 1'b1; strb[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h99;
        @(negedge clk);
        chk("addr_ok_in_reset", addr_ok[0], 1'b0);
        chk("data_ok_in_reset", data_ok[0], 1'b0);
        @(posedge clk); #1;
        reset  = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("outstanding_after_reset", outst[i], 3'd0);
        chk("addr_ok_idle", addr_ok[1], 1'b0);
        @(posedge clk); #1;

        // Word write/read, byte strobes, address aliasing, RAW ordering
        issue(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        issue(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 32'h0, 0);
        issue(0, 1'b1, 4'b0100, 32'h20, 32'hAAAA_AAAA, 32'h0, 0);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11AA_3344, 0);
        issue(0, 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'h0, 0);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11AA_3344, 0);
        issue(0, 1'b1, 4'b0011, 32'h22, 32'h5555_5555, 32'h0, 0);
        issue(0, 1'b0, 4'h0, 32'h1023, 32'h0, 32'h11AA_5555, 0);
        issue(0, 1'b1, 4'hF, 32'h40, 32'h5, 32'h0, 0);
        issue(0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h5, 0);
        req[0] = 1'b0;
        drain(0);
        chk("outstanding0_drained", outst[0], 3'd0);

        // Preload instance 1, then back-to-back reads into a full queue
        for (int k = 0; k < 6; k++) issue(1, 1'b1, 4'hF, 32'(4 * k), pre_v[k], 32'h0, -1);
        issue(1, 1'b1, 4'hF, 32'h64, 32'h6464_6464, 32'h0, -1);
        req[1] = 1'b0;
        drain(1);
        for (int k = 0; k < 4; k++) issue(1, 1'b0, 4'h0, 32'(4 * k), 32'h0, pre_v[k], 0);
        @(negedge clk);
        chk("outstanding_full", outst[1], 3'd4);
        chk("addr_ok_full", addr_ok[1], 1'b0);
        @(posedge clk); #1;
        issue(1, 1'b0, 4'h0, 32'h10, 32'h0, pre_v[4], 1);
        issue(1, 1'b0, 4'h0, 32'h14, 32'h0, pre_v[5], 0);
        req[1] = 1'b0;
        drain(1);

        // Accept delay with ADDR_LAT=2
        issue(2, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 2);
        issue(2, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 2);
        req[2] = 1'b0;
        @(posedge clk); #1;
        req[2] = 1'b1;
        @(negedge clk);
        chk("addr_ok_after_1_cycle", addr_ok[2], 1'b0);
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        issue(2, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 2);
        req[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset with three requests in flight
        issue(1, 1'b1, 4'hF, 32'h60, 32'h1234_5678, 32'h0, 0);
        issue(1, 1'b0, 4'h0, 32'h0, 32'h0, pre_v[0], 0);
        issue(1, 1'b0, 4'h0, 32'h4, 32'h0, pre_v[1], 0);
        reset = 1'b1;
        q1.delete();
        last[1] = -100;
        wr[1] = 1'b1; strb[1] = 4'hF; addr[1] = 32'h64; wdata[1] = 32'h0000_0BAD;
        @(negedge clk);
        chk("addr_ok_in_reset1", addr_ok[1], 1'b0);
        @(posedge clk); #1;
        reset  = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        chk("outstanding_after_midreset", outst[1], 3'd0);
        repeat (10) @(posedge clk);
        #1;
        issue(1, 1'b0, 4'h0, 32'h60, 32'h0, 32'h1234_5678, 0);
        issue(1, 1'b0, 4'h0, 32'h64, 32'h0, 32'h6464_6464, 0);
        req[1] = 1'b0;
        drain(1);
        chk("outstanding1_final", outst[1], 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
